// File: rtl/sign_magnitude_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first, one bit per clock.
// Uses the "copy through the first 1, then invert" rule; latency is WIDTH shift cycles.
module sign_magnitude_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Sign,
  output logic [WIDTH-1:0] Mag
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] acc;
  logic             s;
  logic             seen_one;
  logic [CW-1:0]    cnt;

  logic             o_bit;
  logic [WIDTH-1:0] acc_nxt;

  // Negative operands invert every bit above the lowest set bit.
  function automatic logic mag_bit(input logic b, input logic inv);
    return inv ? ~b : b;
  endfunction

  always_comb begin
    o_bit   = mag_bit(sh[0], s & seen_one);
    acc_nxt = {o_bit, acc[WIDTH-1:1]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      acc      <= '0;
      s        <= 1'b0;
      seen_one <= 1'b0;
      cnt      <= '0;
      Sign     <= 1'b0;
      Mag      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh       <= In;
            s        <= In[WIDTH-1];
            seen_one <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc      <= acc_nxt;
          sh       <= sh >> 1;
          seen_one <= seen_one | sh[0];
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            Mag   <= acc_nxt;
            Sign  <= s;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_magnitude_decoder.sv
// Randomized and directed bench for sign_magnitude_decoder (WIDTH=4) against an
// arithmetic reference: Sign = operand < 0, Mag = |operand| as unsigned.
module tb_sign_magnitude_decoder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] In = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         Sign;
  logic [W-1:0] Mag;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = 0;

  sign_magnitude_decoder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .In(In),
    .out_valid(out_valid), .out_ready(out_ready), .Sign(Sign), .Mag(Mag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, wait for its result, optionally stall the consumer,
  // optionally poke in_valid/In during SHIFT, and optionally check the II.
  task automatic run_word(input logic [W-1:0] w, input int stall, input bit poke, input bit chk_ii);
    int sv;
    int exp_mag;
    int waited;
    logic exp_sign;
    sv       = int'($signed(w));
    exp_mag  = (sv < 0) ? -sv : sv;
    exp_sign = (sv < 0);

    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);

    In        = w;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    if (chk_ii) check("ii", 32'(cyc - last_acc), 32'd6);
    last_acc  = cyc;
    in_valid  = 1'b0;
    In        = W'($urandom);

    waited = 0;
    while (!out_valid && waited < 20) begin
      if (poke && waited < 2) begin
        in_valid = 1'b1;
        In       = ~w;
      end else begin
        in_valid = 1'b0;
      end
      check("busy_in_ready", 32'(in_ready), 32'd0);
      tick();
      waited++;
    end
    in_valid = 1'b0;
    check("latency", 32'(waited), 32'(W));
    check("sign", 32'(Sign), 32'(exp_sign));
    check("mag", 32'(Mag), 32'(exp_mag));

    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_sign", 32'(Sign), 32'(exp_sign));
      check("stall_mag", 32'(Mag), 32'(exp_mag));
    end
    out_ready = 1'b1;
    tick();
    check("consume_in_ready", 32'(in_ready), 32'd1);
    check("consume_valid", 32'(out_valid), 32'd0);

    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check("no_extra_result", 32'(out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    // Reset asserted between edges must take effect immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sign", 32'(Sign), 32'd0);
    check("rst_mag", 32'(Mag), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_word(4'b0101, 0, 1'b0, 1'b0);
    run_word(4'b1011, 0, 1'b0, 1'b0);
    run_word(4'b1111, 0, 1'b0, 1'b0);
    run_word(4'b1000, 0, 1'b0, 1'b0);
    run_word(4'b0000, 0, 1'b0, 1'b0);
    run_word(4'b0111, 0, 1'b0, 1'b0);
    run_word(4'b1101, 3, 1'b0, 1'b0);
    run_word(4'b1001, 0, 1'b1, 1'b0);

    // Reset in the middle of a conversion drops the word.
    in_valid = 1'b1;
    In       = 4'b1010;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_mag", 32'(Mag), 32'd0);
    check("midrst_sign", 32'(Sign), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_word(4'b0011, 0, 1'b0, 1'b0);

    // Back-to-back sweep of every input value.
    for (int v = 0; v < (1 << W); v++) begin
      run_word(W'(v), 0, 1'b0, v != 0);
    end

    for (int k = 0; k < 40; k++) begin
      run_word(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
